// File: rtl/rng_pkg.sv
// Shared widths, word type and the Von Neumann pair decoder for the RNG packer.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package rng_pkg;

  localparam int RNG_WORD_W     = 32;
  localparam int RNG_FIFO_DEPTH = 4;

  typedef logic [RNG_WORD_W-1:0] rng_word_t;

  // Returns {emit, bit}: 01 -> emit 0, 10 -> emit 1, 00/11 -> nothing.
  function automatic logic [1:0] vn_debias(input logic [1:0] pair);
    case (pair)
      2'b01:   return 2'b10;
      2'b10:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/rng_fifo.sv
// Synchronous show-ahead FIFO; head word is held in a register.
// Latency: a word pushed into an empty FIFO is visible on dout one cycle later.
// Backpressure: push is refused when full unless a pop happens on the same edge.
module rng_fifo
  import rng_pkg::*;
#(
  parameter int WIDTH = RNG_WORD_W,
  parameter int DEPTH = RNG_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] head_nxt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wr_nxt  = do_push ? wr_ptr + (AW+1)'(1) : wr_ptr;
  assign rd_nxt  = do_pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;

  // Next head: bypass the incoming word when it lands in the slot becoming head.
  always_comb begin
    head_nxt = mem[rd_nxt[AW-1:0]];
    if (do_push && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) head_nxt = din;
  end

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointers and the registered head word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      dout   <= (wr_nxt == rd_nxt) ? '0 : head_nxt;
    end
  end

endmodule

// File: rtl/rng_packer.sv
// Packs accepted raw random bits (first bit -> MSB) into words buffered in a FIFO.
// Latency: word valid one cycle after the edge accepting its last bit; optional Von Neumann debias via RNG_PACKER_VON_NEUMANN_EN.
// Backpressure: none upstream; a completed word meeting a full FIFO with no pop is dropped and sets sticky overflow.
module rng_packer
  import rng_pkg::*;
#(
  parameter int WIDTH = RNG_WORD_W,
  parameter int DEPTH = RNG_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run_en,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic [WIDTH-1:0]        dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic                    overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             accept, shift_en, shift_bit, word_done;
  logic [WIDTH-1:0] word_data;
  logic             fifo_full, fifo_empty;

  assign accept = run_en && bit_valid;

`ifdef RNG_PACKER_VON_NEUMANN_EN
  logic       pair_vld, pair_bit;
  logic [1:0] vn;

  assign vn        = vn_debias({pair_bit, bit_in});
  assign shift_en  = accept && pair_vld && vn[1];
  assign shift_bit = vn[0];

  // Hold the first bit of each pair; leaving RUN abandons a half pair.
  always_ff @(posedge clk) begin
    if (rst || !run_en) begin
      pair_vld <= 1'b0;
      pair_bit <= 1'b0;
    end else if (accept) begin
      pair_vld <= !pair_vld;
      pair_bit <= bit_in;
    end
  end
`else
  assign shift_en  = accept;
  assign shift_bit = bit_in;
`endif

  assign word_done = shift_en && (cnt == LAST);
  assign word_data = {sreg[WIDTH-2:0], shift_bit};

  // Shift in bits and count them; a partial word is dropped whenever RUN is left.
  always_ff @(posedge clk) begin
    if (rst || !run_en) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      sreg <= word_data;
      cnt  <= word_done ? '0 : cnt + CW'(1);
    end
  end

  // Sticky drop flag: a pop on the same edge frees the slot, so no drop then.
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (word_done && fifo_full && !dout_ready) overflow <= 1'b1;
  end

  rng_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (word_done),
    .din   (word_data),
    .pop   (dout_ready),
    .dout  (dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fill_level)
  );

  assign dout_valid = !fifo_empty;

endmodule

// File: tb/tb_rng_packer.sv
// Bench for rng_packer at WIDTH=8, DEPTH=4: directed steps plus random traffic
// compared each cycle against a word-queue reference model.
module tb_rng_packer;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst, run_en, bit_in, bit_valid, dout_ready;
  logic [W-1:0] dout;
  logic         dout_valid, overflow;
  logic [2:0]   fill_level;

  rng_packer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .run_en     (run_en),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .fill_level (fill_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [W-1:0] q[$];
  int           acc, nb;
  bit           m_ovf, pair_have, pair_first;

  // Last sampled DUT outputs
  logic [W-1:0] cur_dout;
  logic         cur_valid, cur_ovf;
  logic [2:0]   cur_level;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    acc = 0; nb = 0; m_ovf = 0; pair_have = 0; pair_first = 0;
  endtask

  // One clock: drive inputs, compare outputs against the model, advance the model.
  task automatic step(input bit r, input bit run, input bit bv, input bit b, input bit rdy);
    bit emit, ebit;
    rst = r; run_en = run; bit_valid = bv; bit_in = b; dout_ready = rdy;
    @(negedge clk);
    cur_dout = dout; cur_valid = dout_valid; cur_level = fill_level; cur_ovf = overflow;
    check("valid", 32'(cur_valid), 32'(q.size() != 0));
    check("level", 32'(cur_level), 32'(q.size()));
    check("ovf",   32'(cur_ovf),   32'(m_ovf));
    if (q.size() != 0) check("dout", 32'(cur_dout), 32'(q[0]));
    if (r) begin
      model_reset();
    end else begin
      if (rdy && q.size() > 0) void'(q.pop_front());
      if (!run) begin
        acc = 0; nb = 0; pair_have = 0;
      end else if (bv) begin
        emit = 0; ebit = 0;
`ifdef RNG_PACKER_VON_NEUMANN_EN
        if (!pair_have) begin
          pair_have = 1; pair_first = b;
        end else begin
          pair_have = 0;
          if (pair_first != b) begin emit = 1; ebit = pair_first; end
        end
`else
        emit = 1; ebit = b;
`endif
        if (emit) begin
          acc = ((acc << 1) | int'(ebit)) & 8'hFF;
          nb++;
          if (nb == W) begin
            if (q.size() < D) q.push_back(W'(acc));
            else m_ovf = 1;
            acc = 0; nb = 0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed_word(input logic [W-1:0] w, input bit rdy_last);
    for (int i = W - 1; i >= 0; i--) step(0, 1, 1, w[i], (i == 0) ? rdy_last : 1'b0);
  endtask

  task automatic drain(output logic [W-1:0] last);
    last = '0;
    repeat (6) begin
      step(0, 1, 0, 0, 1);
      if (cur_valid) last = cur_dout;
    end
  endtask

  initial begin
    logic [W-1:0] last;
    logic [W-1:0] pat;
    rst = 1; run_en = 1; bit_valid = 1; bit_in = 1; dout_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state, held through two cycles of run_en=1 with no bits
    step(0, 1, 0, 0, 0);
    check("rst_valid", 32'(cur_valid), 32'd0);
    check("rst_level", 32'(cur_level), 32'd0);
    step(0, 1, 0, 0, 0);
    check("rst_ovf", 32'(cur_ovf), 32'd0);

`ifndef RNG_PACKER_VON_NEUMANN_EN
    // 1,0,1,0,0,1,0,1 packs to 0xA5
    pat = 8'hA5;
    feed_word(pat, 0);
    step(0, 1, 0, 0, 0);
    check("a5_dout",  32'(cur_dout),  32'h0A5);
    check("a5_valid", 32'(cur_valid), 32'd1);
    check("a5_level", 32'(cur_level), 32'd1);
    step(0, 1, 0, 0, 1);

    // Partial word discarded when run_en drops
    step(0, 1, 1, 1, 0); step(0, 1, 1, 0, 0); step(0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    feed_word(8'hFF, 0);
    step(0, 1, 0, 0, 0);
    check("ff_dout",  32'(cur_dout),  32'h0FF);
    check("ff_level", 32'(cur_level), 32'd1);
    step(0, 1, 0, 0, 1);

    // Overflow: fifth word into a full FIFO is dropped
    step(1, 1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) feed_word(W'(k), 0);
    step(0, 1, 0, 0, 0);
    check("ovf_set",   32'(cur_ovf),   32'd1);
    check("ovf_level", 32'(cur_level), 32'd4);
    for (int k = 1; k <= 4; k++) begin
      step(0, 1, 0, 0, 1);
      check("ovf_order", 32'(cur_dout), 32'(k));
    end

    // Push into full FIFO with a pop on the same edge
    step(1, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) feed_word(W'(k), 0);
    feed_word(8'h06, 1);
    step(0, 1, 0, 0, 0);
    check("pp_ovf",   32'(cur_ovf),   32'd0);
    check("pp_level", 32'(cur_level), 32'd4);
    drain(last);
    check("pp_last", 32'(last), 32'h006);

    // Reset mid-word with a non-empty FIFO
    feed_word(8'h3C, 0);
    step(0, 1, 1, 1, 0); step(0, 1, 1, 0, 0);
    step(1, 1, 1, 1, 0);
    step(0, 1, 0, 0, 0);
    check("mid_rst_valid", 32'(cur_valid), 32'd0);
    check("mid_rst_level", 32'(cur_level), 32'd0);
`else
    // Debias: pairs 01,10,00,11,10,01,10,10,01,01 -> 0x6C
    begin
      logic [19:0] pairs;
      pairs = 20'b01_10_00_11_10_01_10_10_01_01;
      for (int i = 19; i >= 0; i--) step(0, 1, 1, pairs[i], 0);
    end
    step(0, 1, 0, 0, 0);
    check("vn_dout",  32'(cur_dout),  32'h06C);
    check("vn_level", 32'(cur_level), 32'd1);
    drain(last);
`endif

    // Random traffic against the model
    step(1, 1, 0, 0, 0);
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0)
        step(1, 1, 0, 0, 0);
      else
        step(0, $urandom_range(0, 19) != 0, $urandom_range(0, 4) != 0,
             1'($urandom_range(0, 1)), $urandom_range(0, 9) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rng_packer.md
Name: rng_packer

Overview:
- Downstream of the fsm/NLFSR core.
- Collects one raw random bit per cycle while the fsm is in RUN (run_en=1) and packs the bits into WIDTH-bit words.
- Buffers completed words in a small FIFO and presents them to the consumer over a valid/ready interface.
- Reports dropped words through a sticky overflow flag.

Parameters:
- WIDTH, 32, output word width in bits (>=2).
- DEPTH, 4, FIFO depth in words (power of two, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high (already decided)
- run_en  in  1  fsm RUN indicator; bits are accepted only while high
- bit_in  in  1  raw random bit
- bit_valid  in  1  bit_in is valid this cycle
- dout  out  WIDTH  head-of-FIFO word
- dout_valid  out  1  FIFO non-empty
- dout_ready  in  1  consumer accepts dout this cycle
- fill_level  out  $clog2(DEPTH)+1  words currently in FIFO
- overflow  out  1  sticky; set when a completed word is dropped

Behaviour:
- Reset: shift register=0, bit counter=0, FIFO empty, dout=0, dout_valid=0, fill_level=0, overflow=0.
- Bit accept: at a posedge, a bit is accepted iff run_en && bit_valid.
  - shift register <= {sreg[WIDTH-2:0], bit_in}, so the first accepted bit ends in dout[WIDTH-1].
  - counter increments.
- Word complete: on the edge where the WIDTH-th bit is accepted:
  - the full word, including that bit, is written to the FIFO tail;
  - counter returns to 0;
  - dout_valid is high from the next cycle if the FIFO was empty, i.e. latency is 1 cycle from the last bit's edge.
- Pop: dout_valid && dout_ready at a posedge removes the head. dout is the registered FIFO head (show-ahead).
- Full FIFO on word complete: word dropped, overflow set to 1, counter restarts at 0.
  - Exception: if a pop occurs on the same edge, the push succeeds (pop-before-push), fill_level is unchanged and overflow is not set.
- Simultaneous push and pop when not full: fill_level unchanged; order is preserved.
- Pop when empty: ignored.
- run_en low: accepted bits stop and the partial word is discarded (counter <= 0 on any cycle with run_en=0).
  - FIFO contents and popping are unaffected.
- overflow clears only on rst.
- Reset mid-word or with a non-empty FIFO: everything is discarded and the block returns to the reset state on the next edge.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally.
  - full = pointers differ only in the MSB; empty = pointers equal.

Optional Feature:
- Macro: RNG_PACKER_VON_NEUMANN_EN.
- Defined: accepted bits are debiased in pairs before packing.
  - First bit of a pair is held in a pair register; the second bit completes the pair.
  - Pair 01 emits 0, pair 10 emits 1, pairs 00/11 emit nothing.
  - An emitted bit enters the shift register on the edge the second bit is accepted.
  - The pair register clears when run_en=0 and on rst.
- Undefined: every accepted bit goes straight to the shift register; no pair register exists.

Decomposition:
- Package rng_pkg holds:
  - RNG_WORD_W=32 and RNG_FIFO_DEPTH=4 defaults;
  - typedef rng_word_t (logic [RNG_WORD_W-1:0]);
  - a vn_debias function returning {emit, bit} from a 2-bit pair.
- One sub-module: rng_fifo (synchronous show-ahead FIFO, parameters WIDTH/DEPTH, push/pop/full/empty/level).
- Packing and debias logic stays in rng_packer.

Test Plan (WIDTH=8, DEPTH=4):
- Reset with run_en=1 -> dout_valid=0, fill_level=0, overflow=0 through the first 2 cycles after rst falls.
- Feed bits 1,0,1,0,0,1,0,1 on consecutive cycles with dout_ready=0 -> next cycle dout=0xA5, dout_valid=1, fill_level=1.
- Feed 3 bits, drop run_en for 1 cycle, then feed 0xFF as 8 bits -> exactly one word, dout=0xFF.
- Fill 4 words (0x01..0x04) with dout_ready=0, then complete 0x05 -> overflow=1, fill_level=4, pops return 0x01..0x04 in order.
- Full FIFO; complete word 0x06 on the same edge as a pop -> overflow stays 0, fill_level=4, last word read is 0x06.
- With RNG_PACKER_VON_NEUMANN_EN: feed pairs 01,10,00,11,10,01,10,10,01,01 -> 8 emitted bits 0,1,1,0,1,1,0,0, dout=0x6C.
